// File: rtl/mm_sequencer_pkg.sv
// Shared types and helpers for the matrix-multiply run sequencer.
package mm_sequencer_pkg;

   // Run-level FSM states; the encoding is shared with the array top.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

   // Bits needed to hold 0..value-1, never less than one bit.
   function automatic int clog2_min1(input int value);
      int bits;
      bits = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 << i) < value) begin
            bits = i + 1;
         end else begin
            bits = bits;
         end
      end
      if (bits == 0) begin
         bits = 1;
      end else begin
         bits = bits;
      end
      return bits;
   endfunction

endpackage

// File: rtl/mm_sequencer_if.sv
// Host-side handshake and tile-strobe bundle of the run sequencer.
interface mm_sequencer_if #(
   parameter int RW = 1,
   parameter int CW = 1
);
   logic          start;
   logic          busy;
   logic          done;
   logic          ctrl_rst;
   logic          enable_row_count;
   logic          init_tile;
   logic          tile_done;
   logic [RW-1:0] tile_row;
   logic [CW-1:0] tile_col;

   // Host / top-level FSM side.
   modport master (
      output start,
      input  busy, done, ctrl_rst, enable_row_count,
      input  init_tile, tile_done, tile_row, tile_col
   );

   // Sequencer side.
   modport slave (
      input  start,
      output busy, done, ctrl_rst, enable_row_count,
      output init_tile, tile_done, tile_row, tile_col
   );
endinterface

// File: rtl/mm_sequencer_pipe_delay.sv
// Reset-clearable shift register; DEPTH=0 collapses to a straight wire.
module mm_sequencer_pipe_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   if (DEPTH == 0) begin : g_wire
      logic unused_s;
      assign unused_s = clk ^ rst;
      assign dout     = din;
   end else begin : g_shift
      logic [WIDTH-1:0] stage_r [DEPTH];

      // Shift one stage per cycle; reset empties the whole line.
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
               stage_r[i] <= {WIDTH{1'b0}};
            end
         end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
               stage_r[i] <= stage_r[i-1];
            end
         end
      end

      assign dout = stage_r[DEPTH-1];
   end

endmodule

// File: rtl/mm_sequencer.sv
// Run-level sequencer for the tiled systolic matrix multiply: walks every
// (row_tile, col_tile, k) beat, then drains the array pipeline before done.
module mm_sequencer
   import mm_sequencer_pkg::*;
#(
   parameter int N1     = 4,
   parameter int N2     = 4,
   parameter int M      = 8,
   parameter int RD_LAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   mm_sequencer_if.slave  bus
);

   localparam int TR       = M / N1;
   localparam int TC       = M / N2;
   localparam int PIPE_LAT = RD_LAT + N1 + N2 - 1;
   localparam int RW       = clog2_min1(TR);
   localparam int CW       = clog2_min1(TC);
   localparam int KW       = clog2_min1(M);
   localparam int DW       = clog2_min1(PIPE_LAT);
   localparam int TW       = 1 + RW + CW;

   localparam logic [KW-1:0] K_LAST     = KW'(M - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(TR - 1);
   localparam logic [CW-1:0] COL_LAST   = CW'(TC - 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

   if ((M % N1) != 0 || (M % N2) != 0) begin : g_bad_geometry
      $error("mm_sequencer: M must be a multiple of both N1 and N2");
   end

   seq_state_t    state_r;
   logic [KW-1:0] k_r;
   logic [RW-1:0] row_r;
   logic [CW-1:0] col_r;
   logic [DW-1:0] drain_r;
   logic          busy_r;
   logic          done_r;
   logic          ctrl_rst_r;
   logic          erc_r;

   logic          raw_init_s;
   logic          raw_tile_s;
   logic          init_out_s;
   logic [TW-1:0] tile_in_s;
   logic [TW-1:0] tile_out_s;

   // Main FSM: beat counters, drain timer and registered state-decoded outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         k_r        <= {KW{1'b0}};
         row_r      <= {RW{1'b0}};
         col_r      <= {CW{1'b0}};
         drain_r    <= {DW{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         ctrl_rst_r <= 1'b1;
         erc_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  state_r    <= ST_RUN;
                  k_r        <= {KW{1'b0}};
                  row_r      <= {RW{1'b0}};
                  col_r      <= {CW{1'b0}};
                  busy_r     <= 1'b1;
                  ctrl_rst_r <= 1'b0;
                  erc_r      <= (COL_LAST == {CW{1'b0}});
               end else begin
                  busy_r     <= 1'b0;
                  ctrl_rst_r <= 1'b1;
                  erc_r      <= 1'b0;
               end
               done_r <= 1'b0;
            end
            ST_RUN: begin
               if (k_r == K_LAST) begin
                  k_r <= {KW{1'b0}};
                  if (col_r == COL_LAST) begin
                     col_r <= {CW{1'b0}};
                     if (row_r == ROW_LAST) begin
                        row_r   <= {RW{1'b0}};
                        state_r <= ST_DRAIN;
                        drain_r <= {DW{1'b0}};
                        erc_r   <= 1'b0;
                     end else begin
                        row_r <= row_r + RW'(1);
                        erc_r <= (COL_LAST == {CW{1'b0}});
                     end
                  end else begin
                     col_r <= col_r + CW'(1);
                     erc_r <= ((col_r + CW'(1)) == COL_LAST);
                  end
               end else begin
                  k_r <= k_r + KW'(1);
               end
            end
            ST_DRAIN: begin
               if (drain_r == DRAIN_LAST) begin
                  state_r    <= ST_DONE;
                  busy_r     <= 1'b0;
                  done_r     <= 1'b1;
                  ctrl_rst_r <= 1'b1;
               end else begin
                  drain_r <= drain_r + DW'(1);
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
            end
            default: begin
               state_r    <= ST_IDLE;
               busy_r     <= 1'b0;
               done_r     <= 1'b0;
               ctrl_rst_r <= 1'b1;
               erc_r      <= 1'b0;
            end
         endcase
      end
   end

   // Undelayed beat strobes: first and last beat of each tile while running.
   always_comb begin
      raw_init_s = 1'b0;
      raw_tile_s = 1'b0;
      if (state_r == ST_RUN) begin
         raw_init_s = (k_r == {KW{1'b0}});
         raw_tile_s = (k_r == K_LAST);
      end else begin
         raw_init_s = 1'b0;
         raw_tile_s = 1'b0;
      end
   end

   assign tile_in_s = {raw_tile_s, row_r, col_r};

   // Accumulator clear lines up with the first beat's data reaching the array.
   mm_sequencer_pipe_delay #(.WIDTH(1), .DEPTH(RD_LAT)) u_init_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (raw_init_s),
      .dout (init_out_s)
   );

   // Tile-complete tuple follows the last beat through read latency and the array.
   mm_sequencer_pipe_delay #(.WIDTH(TW), .DEPTH(PIPE_LAT)) u_tile_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (tile_in_s),
      .dout (tile_out_s)
   );

   assign bus.busy             = busy_r;
   assign bus.done             = done_r;
   assign bus.ctrl_rst         = ctrl_rst_r;
   assign bus.enable_row_count = erc_r;
   assign bus.init_tile        = init_out_s;
   assign bus.tile_done        = tile_out_s[TW-1];
   assign bus.tile_row         = tile_out_s[CW +: RW];
   assign bus.tile_col         = tile_out_s[CW-1:0];

endmodule
